// File: rtl/mm_pkg.sv
// mm_pkg: shared state encoding and default geometry for the matrix-multiply operand streamer.
package mm_pkg;
  localparam int DEF_DATA_WIDTH  = 64;
  localparam int DEF_A_NUM_WIDTH = 3;
  localparam int DEF_B_NUM_WIDTH = 3;
  localparam int DEF_N_MAX_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH  = 16;
  localparam int SI = 1 << DEF_A_NUM_WIDTH;
  localparam int SJ = 1 << DEF_B_NUM_WIDTH;
  typedef enum logic [1:0] {IDLE, A_PH, B_PH, FIN} state_t;
endpackage

// File: rtl/mm_tile_addr_gen.sv
// mm_tile_addr_gen: nested i/j/n/ii/jj counters with incremental A and B RAM address adders.
module mm_tile_addr_gen import mm_pkg::*; #(
  parameter int A_NUM_WIDTH = DEF_A_NUM_WIDTH,
  parameter int B_NUM_WIDTH = DEF_B_NUM_WIDTH,
  parameter int N_MAX_WIDTH = DEF_N_MAX_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic                   adv_i,
  input  logic                   b_ph_i,
  input  logic [N_MAX_WIDTH-1:0] mt_i,
  input  logic [N_MAX_WIDTH-1:0] n_i,
  input  logic [N_MAX_WIDTH-1:0] kt_i,
  input  logic [N_MAX_WIDTH-1:0] k_i,
  input  logic [ADDR_WIDTH-1:0]  a_base_i,
  input  logic [ADDR_WIDTH-1:0]  b_base_i,
  output logic [ADDR_WIDTH-1:0]  a_addr_o,
  output logic [ADDR_WIDTH-1:0]  b_addr_o,
  output logic                   ii_last_o,
  output logic                   jj_last_o,
  output logic                   n_last_o,
  output logic                   j_last_o,
  output logic                   i_last_o
);
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] SJ_W  = A_ONE << B_NUM_WIDTH;
  localparam logic [N_MAX_WIDTH-1:0] N_ONE = N_MAX_WIDTH'(1);
  logic [A_NUM_WIDTH-1:0] ii_q;
  logic [B_NUM_WIDTH-1:0] jj_q;
  logic [N_MAX_WIDTH-1:0] n_q, i_q, j_q, nd_q, mt_q, kt_q;
  logic [ADDR_WIDTH-1:0]  nw_q, kw_q, a_row_q, a_col_q, a_addr_q;
  logic [ADDR_WIDTH-1:0]  b_base_q, b_tile_q, b_row_q, b_addr_q;
  logic [ADDR_WIDTH-1:0]  a_next_row, b_next_tile;
  assign ii_last_o   = &ii_q;
  assign jj_last_o   = &jj_q;
  assign n_last_o    = n_q == nd_q - N_ONE;
  assign j_last_o    = j_q == kt_q - N_ONE;
  assign i_last_o    = i_q == mt_q - N_ONE;
  assign a_addr_o    = a_addr_q;
  assign b_addr_o    = b_addr_q;
  // a tile row step is Si*N words, a shift rather than a multiply
  assign a_next_row  = a_row_q + (nw_q << A_NUM_WIDTH);
  assign b_next_tile = b_tile_q + SJ_W;
  always_ff @(posedge clk)
    if (!rst) begin
      ii_q <= '0; jj_q <= '0; n_q <= '0; i_q <= '0; j_q <= '0;
      nd_q <= '0; mt_q <= '0; kt_q <= '0; nw_q <= '0; kw_q <= '0;
      a_row_q <= '0; a_col_q <= '0; a_addr_q <= '0;
      b_base_q <= '0; b_tile_q <= '0; b_row_q <= '0; b_addr_q <= '0;
    end else if (load_i) begin
      ii_q <= '0; jj_q <= '0; n_q <= '0; i_q <= '0; j_q <= '0;
      nd_q <= n_i; mt_q <= mt_i; kt_q <= kt_i;
      nw_q <= ADDR_WIDTH'(n_i); kw_q <= ADDR_WIDTH'(k_i);
      a_row_q <= a_base_i; a_col_q <= a_base_i; a_addr_q <= a_base_i;
      b_base_q <= b_base_i; b_tile_q <= b_base_i; b_row_q <= b_base_i; b_addr_q <= b_base_i;
    end else if (adv_i && !b_ph_i) begin
      ii_q     <= ii_q + A_NUM_WIDTH'(1);
      a_addr_q <= ii_last_o ? a_col_q : a_addr_q + nw_q;
    end else if (adv_i) begin
      jj_q <= jj_q + B_NUM_WIDTH'(1);
      if (!jj_last_o) begin
        b_addr_q <= b_addr_q + A_ONE;
      end else if (!n_last_o) begin
        n_q      <= n_q + N_ONE;
        a_col_q  <= a_col_q + A_ONE;
        a_addr_q <= a_col_q + A_ONE;
        b_row_q  <= b_row_q + kw_q;
        b_addr_q <= b_row_q + kw_q;
      end else if (!j_last_o) begin
        n_q      <= '0;
        j_q      <= j_q + N_ONE;
        a_col_q  <= a_row_q;
        a_addr_q <= a_row_q;
        b_tile_q <= b_next_tile;
        b_row_q  <= b_next_tile;
        b_addr_q <= b_next_tile;
      end else begin
        n_q      <= '0;
        j_q      <= '0;
        i_q      <= i_q + N_ONE;
        a_row_q  <= a_next_row;
        a_col_q  <= a_next_row;
        a_addr_q <= a_next_row;
        b_tile_q <= b_base_q;
        b_row_q  <= b_base_q;
        b_addr_q <= b_base_q;
      end
    end
endmodule

// File: rtl/mm_operand_streamer.sv
// mm_operand_streamer: reads A and B from row-major operand RAMs and streams them in tile order.
module mm_operand_streamer import mm_pkg::*; #(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int A_NUM_WIDTH = DEF_A_NUM_WIDTH,
  parameter int B_NUM_WIDTH = DEF_B_NUM_WIDTH,
  parameter int N_MAX_WIDTH = DEF_N_MAX_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_in,
  input  logic [N_MAX_WIDTH-1:0] M_in,
  input  logic [N_MAX_WIDTH-1:0] N_in,
  input  logic [N_MAX_WIDTH-1:0] K_in,
  input  logic [ADDR_WIDTH-1:0]  a_base_in,
  input  logic [ADDR_WIDTH-1:0]  b_base_in,
  input  logic                   stall_in,
  output logic                   a_rd_en_out,
  output logic [ADDR_WIDTH-1:0]  a_rd_addr_out,
  input  logic [DATA_WIDTH-1:0]  a_rd_data_in,
  output logic                   b_rd_en_out,
  output logic [ADDR_WIDTH-1:0]  b_rd_addr_out,
  input  logic [DATA_WIDTH-1:0]  b_rd_data_in,
  output logic [DATA_WIDTH-1:0]  A_out,
  output logic                   A_valid_out,
  output logic [DATA_WIDTH-1:0]  B_out,
  output logic                   B_valid_out,
  output logic                   busy_out,
  output logic                   done_out
);
  state_t state_q;
  logic a_vld_q, b_vld_q, busy_q, done_q;
  logic [N_MAX_WIDTH-1:0] mt, kt;
  logic [ADDR_WIDTH-1:0] a_addr, b_addr;
  logic zero_dim, accept, b_ph, ii_last, jj_last, n_last, j_last, i_last;
  assign mt       = M_in >> A_NUM_WIDTH;
  assign kt       = K_in >> B_NUM_WIDTH;
  assign zero_dim = mt == '0 || N_in == '0 || kt == '0;
  // busy stays high through the done cycle, so a start there is ignored
  assign accept   = state_q == IDLE && start_in && !busy_q;
  assign b_ph     = state_q == B_PH;
  // read enables are combinational so a stall blocks a read in the same cycle
  assign a_rd_en_out   = state_q == A_PH && !stall_in;
  assign b_rd_en_out   = b_ph && !stall_in;
  assign a_rd_addr_out = a_rd_en_out ? a_addr : '0;
  assign b_rd_addr_out = b_rd_en_out ? b_addr : '0;
  assign A_valid_out   = a_vld_q;
  assign B_valid_out   = b_vld_q;
  assign A_out         = a_vld_q ? a_rd_data_in : '0;
  assign B_out         = b_vld_q ? b_rd_data_in : '0;
  assign busy_out      = busy_q;
  assign done_out      = done_q;
  mm_tile_addr_gen #(
    .A_NUM_WIDTH(A_NUM_WIDTH),
    .B_NUM_WIDTH(B_NUM_WIDTH),
    .N_MAX_WIDTH(N_MAX_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_gen (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept),
    .adv_i    (a_rd_en_out | b_rd_en_out),
    .b_ph_i   (b_ph),
    .mt_i     (mt),
    .n_i      (N_in),
    .kt_i     (kt),
    .k_i      (K_in),
    .a_base_i (a_base_in),
    .b_base_i (b_base_in),
    .a_addr_o (a_addr),
    .b_addr_o (b_addr),
    .ii_last_o(ii_last),
    .jj_last_o(jj_last),
    .n_last_o (n_last),
    .j_last_o (j_last),
    .i_last_o (i_last)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= IDLE;
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_q == IDLE ? (accept ? (zero_dim ? FIN : A_PH) : IDLE)
               : state_q == A_PH ? (a_rd_en_out && ii_last ? B_PH : A_PH)
               : state_q == B_PH ? (b_rd_en_out && jj_last ? (n_last && j_last && i_last ? FIN : A_PH) : B_PH)
               : IDLE;
      a_vld_q <= a_rd_en_out;
      b_vld_q <= b_rd_en_out;
      done_q  <= state_q == FIN;
      busy_q  <= accept | (busy_q & ~done_q);
    end
endmodule

// File: tb/tb_mm_operand_streamer.sv
// tb_mm_operand_streamer: table-driven jobs with a stream scoreboard plus reset/stall/back-to-back sequences.
module tb_mm_operand_streamer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_in = 1'b0, stall_in = 1'b0;
  logic [31:0] M_in = '0, N_in = '0, K_in = '0;
  logic [15:0] a_base_in = '0, b_base_in = '0;
  logic a_rd_en_out, b_rd_en_out, A_valid_out, B_valid_out, busy_out, done_out;
  logic [15:0] a_rd_addr_out, b_rd_addr_out;
  logic [63:0] a_rd_data_in = '0, b_rd_data_in = '0, A_out, B_out;

  typedef struct packed { logic is_b; logic [63:0] data; } exp_t;
  typedef struct { int m, n, k, ab, bb, stall_at, words, lat; } vec_t;
  exp_t exp_q[$];
  int tests = 0, fails = 0, words_seen = 0, rd_seen = 0;

  mm_operand_streamer dut (
    .clk(clk), .rst(rst), .start_in(start_in),
    .M_in(M_in), .N_in(N_in), .K_in(K_in),
    .a_base_in(a_base_in), .b_base_in(b_base_in), .stall_in(stall_in),
    .a_rd_en_out(a_rd_en_out), .a_rd_addr_out(a_rd_addr_out), .a_rd_data_in(a_rd_data_in),
    .b_rd_en_out(b_rd_en_out), .b_rd_addr_out(b_rd_addr_out), .b_rd_data_in(b_rd_data_in),
    .A_out(A_out), .A_valid_out(A_valid_out), .B_out(B_out), .B_valid_out(B_valid_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] a_word(input logic [15:0] addr);
    return {16'hA11A, 32'h0, addr};
  endfunction
  function automatic logic [63:0] b_word(input logic [15:0] addr);
    return {16'hB22B, 32'h0, addr};
  endfunction

  // synchronous-read RAMs whose contents encode their own address
  always @(posedge clk) begin
    if (a_rd_en_out) a_rd_data_in <= a_word(a_rd_addr_out);
    if (b_rd_en_out) b_rd_data_in <= b_word(b_rd_addr_out);
  end

  task automatic check(input string nm, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  always @(negedge clk)
    if (rst) begin
      if (a_rd_en_out || b_rd_en_out) rd_seen++;
      if (A_valid_out || B_valid_out) begin
        exp_t e;
        words_seen++;
        tests++;
        if (A_valid_out && B_valid_out) begin
          fails++;
          $display("FAIL both_valid: A and B valid together at word %0d", words_seen);
        end else if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_word: got is_b=%0d data=%h with empty scoreboard", B_valid_out, B_valid_out ? B_out : A_out);
        end else begin
          e = exp_q.pop_front();
          if (e.is_b !== B_valid_out || e.data !== (B_valid_out ? B_out : A_out)) begin
            fails++;
            $display("FAIL stream_word %0d: got is_b=%0d data=%h expected is_b=%0d data=%h",
                     words_seen, B_valid_out, B_valid_out ? B_out : A_out, e.is_b, e.data);
          end
        end
      end
    end

  task automatic push_expected(input int m, input int n, input int k, input int ab, input int bb);
    int mt = m >> 3;
    int kt = k >> 3;
    for (int i = 0; i < mt; i++)
      for (int j = 0; j < kt; j++)
        for (int nn = 0; nn < n; nn++) begin
          for (int ii = 0; ii < 8; ii++) exp_q.push_back({1'b0, a_word(16'(ab + (i * 8 + ii) * n + nn))});
          for (int jj = 0; jj < 8; jj++) exp_q.push_back({1'b1, b_word(16'(bb + nn * k + j * 8 + jj))});
        end
  endtask

  // starts the job in the current cycle so a call right after a done pulse tests back-to-back starts
  task automatic run_job(input vec_t v);
    int edges = 0, lat = -1, w0, r0, busy_n, sc = 0, sw0 = 0;
    bit stalling = 0, stall_done = 0;
    M_in = v.m; N_in = v.n; K_in = v.k;
    a_base_in = 16'(v.ab); b_base_in = 16'(v.bb);
    start_in = 1'b1;
    push_expected(v.m, v.n, v.k, v.ab, v.bb);
    w0 = words_seen; r0 = rd_seen;
    @(posedge clk); #1;
    start_in = 1'b0;
    busy_n = int'(busy_out);
    while (lat < 0 && edges < 5000) begin
      @(posedge clk); #1;
      edges++;
      busy_n += int'(busy_out);
      if (done_out) lat = edges;
      if (edges == 5) begin start_in = 1'b1; M_in = 32; end
      else if (edges == 6) begin start_in = 1'b0; M_in = v.m; end
      if (v.stall_at >= 0) begin
        if (!stalling && !stall_done && words_seen - w0 >= v.stall_at) begin
          stall_in = 1'b1; stalling = 1; sw0 = words_seen; sc = 0;
        end else if (stalling) begin
          sc++;
          if (sc == 5) begin
            check("stall_drain_words", words_seen - sw0, 1);
            stall_in = 1'b0; stalling = 0; stall_done = 1;
          end
        end
      end
    end
    start_in = 1'b0;
    stall_in = 1'b0;
    check("done_latency", lat, v.lat);
    check("word_count", words_seen - w0, v.words);
    check("read_count", rd_seen - r0, v.words);
    check("busy_cycles", busy_n, v.lat + 1);
    check("scoreboard_left", exp_q.size(), 0);
    @(posedge clk); #1;
    check("idle_after_done", {busy_out, done_out}, 0);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_ctrl"}, {a_rd_en_out, b_rd_en_out, A_valid_out, B_valid_out, busy_out, done_out}, 0);
    check({nm, "_addr"}, {a_rd_addr_out, b_rd_addr_out}, 0);
    check({nm, "_A_out"}, longint'(A_out), 0);
    check({nm, "_B_out"}, longint'(B_out), 0);
  endtask

  initial begin
    vec_t vt[7];
    vec_t full;
    int g, w1;
    vt[0] = '{16, 16, 16, 0,      0,      -1, 1024, 1025};
    vt[1] = '{20,  4, 12, 0,      0,      -1,  128,  129};
    vt[2] = '{16,  0, 16, 0,      0,      -1,    0,    1};
    vt[3] = '{ 7,  4, 16, 0,      0,      -1,    0,    1};
    vt[4] = '{16, 16, 16, 'h100,  'h200,   3, 1024, 1030};
    vt[5] = '{ 8,  2,  8, 'hFFF8, 'hFFFC, -1,   32,   33};
    vt[6] = '{ 8,  3, 16, 'h100,  'h200,  -1,   96,   97};
    full = vt[0];
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    for (int t = 0; t < 7; t++) run_job(vt[t]);
    M_in = 16; N_in = 16; K_in = 16; a_base_in = '0; b_base_in = '0;
    start_in = 1'b1;
    push_expected(16, 16, 16, 0, 0);
    @(posedge clk); #1;
    start_in = 1'b0;
    w1 = words_seen;
    g = 0;
    while (words_seen - w1 < 300 && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    check("words_before_reset", words_seen - w1, 300);
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("mid_reset");
    rst = 1'b1;
    exp_q.delete();
    w1 = words_seen;
    repeat (3) @(posedge clk);
    #1;
    check("no_valid_after_reset", words_seen - w1, 0);
    run_job(full);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
